// File: rtl/pattern_serializer_if.sv
// Word-in / bit-out bus of the pattern serializer.
// The master side is the upstream word source; the slave side is the serializer.
interface pattern_serializer_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;
    logic             serial_pattern;
    logic             enable;
    logic             word_done;
    logic             busy;

    modport master (
        output in_data, in_valid,
        input  in_ready, serial_pattern, enable, word_done, busy
    );

    modport slave (
        input  in_data, in_valid,
        output in_ready, serial_pattern, enable, word_done, busy
    );
endinterface

// File: rtl/pattern_serializer.sv
// Parallel-to-serial front end for the serial pattern detector: one buffered word,
// gapless back-to-back streaming, enable low whenever no data bit is on the line.
module pattern_serializer #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                clk,
    input  logic                rstb,
    input  logic                clr,
    pattern_serializer_if.slave bus
);
    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] hold_reg, hold_next;
    logic             hold_valid_reg, hold_valid_next;
    logic [WIDTH-1:0] sr_reg, sr_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             serial_reg, serial_next;
    logic [WIDTH-1:0] hold_ord;
    logic             accept;
    logic             last_bit;

    // hold_ord puts the first bit to transmit at the top, so the shifter only ever rotates left.
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_order
            if (MSB_FIRST) begin : g_msb
                assign hold_ord[gi] = hold_reg[gi];
            end else begin : g_lsb
                assign hold_ord[gi] = hold_reg[WIDTH-1-gi];
            end
        end
    endgenerate

    assign accept   = bus.in_valid && !hold_valid_reg && !clr;
    assign last_bit = (cnt_reg == CNT_LAST);

    assign bus.in_ready       = !hold_valid_reg && !clr;
    assign bus.serial_pattern = serial_reg;
    assign bus.enable         = (state_reg == SHIFT);
    assign bus.word_done      = (state_reg == SHIFT) && last_bit;
    assign bus.busy           = (state_reg == SHIFT) || hold_valid_reg;

    always_comb begin
        state_next      = state_reg;
        hold_next       = hold_reg;
        hold_valid_next = hold_valid_reg;
        sr_next         = sr_reg;
        cnt_next        = cnt_reg;
        serial_next     = serial_reg;

        // accept needs an empty holding register, a load needs a full one: never both.
        if (accept) begin
            hold_next       = bus.in_data;
            hold_valid_next = 1'b1;
        end

        if (clr) begin
            state_next      = IDLE;
            hold_valid_next = 1'b0;
            cnt_next        = '0;
            serial_next     = 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    serial_next = 1'b0;
                    if (hold_valid_reg) begin
                        state_next      = SHIFT;
                        sr_next         = hold_ord;
                        serial_next     = hold_ord[WIDTH-1];
                        cnt_next        = '0;
                        hold_valid_next = 1'b0;
                    end
                end
                SHIFT: begin
                    if (!last_bit) begin
                        sr_next     = {sr_reg[WIDTH-2:0], sr_reg[WIDTH-1]};
                        serial_next = sr_reg[WIDTH-2];
                        cnt_next    = cnt_reg + 1'b1;
                    end else if (hold_valid_reg) begin
                        sr_next         = hold_ord;
                        serial_next     = hold_ord[WIDTH-1];
                        cnt_next        = '0;
                        hold_valid_next = 1'b0;
                    end else begin
                        state_next  = IDLE;
                        serial_next = 1'b0;
                        cnt_next    = '0;
                    end
                end
                default: begin
                    state_next  = IDLE;
                    serial_next = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state_reg      <= IDLE;
            hold_reg       <= '0;
            hold_valid_reg <= 1'b0;
            sr_reg         <= '0;
            cnt_reg        <= '0;
            serial_reg     <= 1'b0;
        end else begin
            state_reg      <= state_next;
            hold_reg       <= hold_next;
            hold_valid_reg <= hold_valid_next;
            sr_reg         <= sr_next;
            cnt_reg        <= cnt_next;
            serial_reg     <= serial_next;
        end
    end
endmodule
